// File: rtl/pool_layer_param_if.sv
// ---------------------------------------------------------------------------
// pool_layer_param_if
// Valid/ready stream carrying one DW-bit word per channel.
//   valid : source has a beat on data
//   ready : sink can take the beat (transfer when valid && ready)
//   data  : packed per-channel words, channel 1..CH, each two's-complement
// Modports:
//   master : source side (drives valid/data, observes ready)
//   slave  : sink side (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface pool_layer_param_if #(
    parameter int CH = 3,
    parameter int DW = 16
);
    logic                  valid;
    logic                  ready;
    logic [CH:1][DW-1:0]   data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pool_layer_param.sv
// ---------------------------------------------------------------------------
// pool_layer_param
// Multi-channel KxK non-overlapping (stride K) pooling layer, max or average
// mode chosen per frame. All CH channels share one control path, so every
// channel produces its pooled pixel in the same cycle.
// Ports:
//   clk        : rising-edge clock
//   n_reset    : asynchronous active-low reset
//   start      : one-cycle pulse starting a frame (restarts a running frame)
//   avg_mode   : sampled on start, 0 = max pooling, 1 = average pooling
//   in_bus     : input pixel stream (slave), one pixel per channel per beat,
//                row-major over an IMG_W x IMG_H feature map
//   out_bus    : pooled pixel stream (master), one word per channel per window
//   frame_done : one-cycle pulse after the final output transfer of a frame
//   err        : one-cycle pulse on input while idle or start during a frame
// ---------------------------------------------------------------------------
module pool_layer_param #(
    parameter int CH    = 3,
    parameter int DW    = 16,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 2
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   start,
    input  logic                   avg_mode,
    pool_layer_param_if.slave      in_bus,
    pool_layer_param_if.master     out_bus,
    output logic                   frame_done,
    output logic                   err
);

    localparam int LOG2K = $clog2(K);
    localparam int SH    = 2 * LOG2K;           // log2 of window area
    localparam int AW    = DW + SH;             // accumulator holds K*K sums
    localparam int NW    = IMG_W / K;           // line buffer entries
    localparam int IW    = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    generate
        if ((K < 2) || ((K & (K - 1)) != 0) || ((IMG_W % K) != 0) || ((IMG_H % K) != 0))
        begin : g_param_check
            $error("pool_layer_param: K must be a power of 2 >= 2 dividing IMG_W and IMG_H");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [CW-1:0]        col_reg;
    logic [RW-1:0]        row_reg;
    logic                 avg_reg;
    logic                 out_valid_reg;
    logic [CH:1][DW-1:0]  out_data_reg;
    logic                 frame_done_reg;
    logic                 err_reg;

    logic                 restart;
    logic                 accept;
    logic                 col_last;
    logic                 row_last;
    logic                 win_first;
    logic                 win_last;
    logic                 flush_done;
    logic [IW-1:0]        lb_idx;
    logic [CH:1][DW-1:0]  res_all;

    // A start while a frame is in flight throws the frame away.
    assign restart   = start && (state_reg != IDLE);

    // Input stalls whenever the output register is occupied and not draining,
    // so a finished window can never overwrite an unconsumed result.
    assign in_bus.ready = (state_reg == RUN) && !(out_valid_reg && !out_bus.ready);

    // A beat presented alongside start belongs to neither frame.
    assign accept    = in_bus.valid && in_bus.ready && !start;

    assign col_last  = (col_reg == CW'(IMG_W - 1));
    assign row_last  = (row_reg == RW'(IMG_H - 1));
    assign win_first = (col_reg[LOG2K-1:0] == '0) && (row_reg[LOG2K-1:0] == '0);
    assign win_last  = (col_reg[LOG2K-1:0] == {LOG2K{1'b1}}) &&
                       (row_reg[LOG2K-1:0] == {LOG2K{1'b1}});
    assign lb_idx    = IW'(col_reg >> LOG2K);

    assign out_bus.valid = out_valid_reg;
    assign out_bus.data  = out_data_reg;
    assign frame_done    = frame_done_reg;
    assign err           = err_reg;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        flush_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (start)
                    state_next = RUN;
                else if (accept && col_last && row_last)
                    state_next = FLUSH;
            end
            FLUSH: begin
                if (start) begin
                    state_next = RUN;
                end else if (!out_valid_reg || out_bus.ready) begin
                    flush_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- position counters and mode ----------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            col_reg <= '0;
            row_reg <= '0;
            avg_reg <= 1'b0;
        end else if (start) begin
            col_reg <= '0;
            row_reg <= '0;
            avg_reg <= avg_mode;
        end else if (accept) begin
            if (col_last) begin
                col_reg <= '0;
                row_reg <= row_last ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // ---------------- per-channel line buffer and combine ----------------
    genvar gi;
    generate
        for (gi = 1; gi <= CH; gi++) begin : g_ch
            logic signed [AW-1:0] lb_mem [NW];
            logic signed [AW-1:0] pix_ext;
            logic signed [AW-1:0] lb_rd;
            logic signed [AW-1:0] acc;

            assign pix_ext = {{SH{in_bus.data[gi][DW-1]}}, in_bus.data[gi]};
            assign lb_rd   = lb_mem[lb_idx];

            always_comb begin
                acc = pix_ext;
                if (!win_first) begin
                    if (avg_reg)
                        acc = lb_rd + pix_ext;
                    else
                        acc = (pix_ext > lb_rd) ? pix_ext : lb_rd;
                end
            end

            // Arithmetic shift gives floor toward minus infinity for the mean;
            // the running max already fits in DW bits.
            assign res_all[gi] = avg_reg ? DW'(acc >>> SH) : DW'(acc);

            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    for (int i = 0; i < NW; i++) lb_mem[i] <= '0;
                end else if (accept) begin
                    lb_mem[lb_idx] <= acc;
                end
            end
        end
    endgenerate

    // ---------------- output register and status pulses ----------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            frame_done_reg <= flush_done;
            err_reg        <= restart || ((state_reg == IDLE) && in_bus.valid);
            if (restart) begin
                out_valid_reg <= 1'b0;
            end else if (accept && win_last) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= res_all;
            end else if (out_bus.ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pool_layer_param.md
Name: pool_layer_param

Overview:
Parametrised multi-channel KxK non-overlapping pooling layer (stride K) for the CNN datapath. It replaces fixed 3-channel pooling with CH channels under one shared control, so per-channel flags can never disagree.
- Input: a row-major feature map, one pixel per channel per accepted beat, over a valid/ready handshake.
- Output: one pooled pixel per channel per window, over a valid/ready handshake.
- Mode: max or average, selectable per frame.

Parameters:
CH, 3, number of channels processed in lockstep
DW, 16, signed data width per channel
IMG_W, 28, input feature map width; must be a multiple of K
IMG_H, 28, input feature map height; must be a multiple of K
K, 2, pooling window edge and stride; power of 2, at least 2

Ports:
clk  input  1  clock, rising edge
n_reset  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that begins a frame
avg_mode  input  1  sampled on start: 0 = max pooling, 1 = average pooling
in_valid  input  1  input beat valid
in_ready  output  1  block can accept an input beat
input_feature  input  [CH:1] x DW signed  one pixel per channel
output_feature  output  [CH:1] x DW signed  pooled pixel per channel
out_valid  output  1  output_feature valid
out_ready  input  1  downstream accepts output
frame_done  output  1  one-cycle pulse after the final output handshake of a frame
err  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (async, n_reset low):
  - state IDLE; all counters and line buffers cleared.
  - output_feature all 0; out_valid, in_ready, frame_done, err = 0.
  - Reset mid-frame abandons the frame; no output follows.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - in_ready = 0.
  - start: latch avg_mode, clear col/row counters, go to RUN.
  - in_valid while IDLE: ignored, err pulses.
- RUN:
  - in_ready = !(out_valid && !out_ready).
  - Beat accepted when in_valid && in_ready.
  - Counters col 0..IMG_W-1 and row 0..IMG_H-1; col wraps to 0 and row increments on each accepted beat at col = IMG_W-1.
- Line buffer:
  - IMG_W/K entries per channel, each DW+2*log2(K) bits.
  - Indexed by col/K; window position is wr = row%K, wc = col%K.
  - Window first element (wr=0, wc=0): load the pixel (sign-extended).
  - Otherwise combine: max mode = signed max; avg mode = signed add.
- Window last element (wr = K-1, wc = K-1) produces a result:
  - Max mode: result is the running max.
  - Avg mode: result is the sum arithmetically shifted right by 2*log2(K), i.e. floor toward minus infinity, truncated to DW.
  - Result is registered into output_feature, and out_valid rises the cycle after the accepting edge (latency 1).
- Output handshake:
  - out_valid and output_feature hold stable until out_valid && out_ready.
  - out_valid then clears unless a new result loads in the same cycle.
  - Backpressure never drops data: in_ready falls while the output is held.
- Frame end:
  - Acceptance of pixel (IMG_H-1, IMG_W-1) moves RUN to FLUSH; in_ready = 0 in FLUSH.
  - frame_done pulses the cycle after the final output handshake; state returns to IDLE.
- start while in RUN or FLUSH:
  - err pulses; pending output and counters discarded; out_valid = 0.
  - avg_mode re-latched; state RUN with a fresh frame.
- Channels share all control, so every channel produces its result in the same cycle.
- Elaboration fails if IMG_W or IMG_H is not a multiple of K, or if K is not a power of 2.

Test Plan:
1. CH=3, K=2, IMG_W=IMG_H=4, max mode; ch1 pixels 1..16 row-major, ch2 = -ch1, ch3 = 0 -> outputs in order ch1 {6,8,14,16}, ch2 {-1,-3,-9,-11}, ch3 all 0; frame_done pulses once after the 4th handshake.
2. Same frame in avg mode -> ch1 {3,5,11,13}; a window {-1,-2,-3,-4} gives -3 (floor of -2.5); a window of four 32767 gives 32767 with no overflow.
3. Max mode extremes: window {-32768, 32767, 0, -1} -> 32767; window of four -32768 -> -32768.
4. Backpressure: out_ready held low for 5 cycles while out_valid = 1 -> in_ready = 0 for those cycles and output_feature stable; all 4 results arrive in order with none lost or duplicated.
5. start pulsed after 7 accepted beats -> err pulses 1 cycle, out_valid = 0; a following full frame yields correct results.
6. n_reset asserted mid-frame, asynchronously between clock edges -> outputs 0 immediately; start plus a full frame after release yields correct results; in_valid while IDLE -> err pulse, no output.
